// File: rtl/ddr_burst_data.sv
// DDR data-phase engine: queues CAS-issued commands and, on each rw_rdy pulse,
// runs one BL-beat write (drive DQ/DQS) or read (capture DQ, return line) burst.
module ddr_burst_data #(
  parameter int unsigned DQ_W  = 8,
  parameter int unsigned BL    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                      clock_t,
  input  logic                      reset,
  input  logic                      cmd_push,
  input  logic [1:0]                cmd_rw,
  input  logic [TAG_W-1:0]          cmd_tag,
  input  logic [BL*DQ_W-1:0]        cmd_wdata,
  input  logic                      rw_rdy,
  input  logic [DQ_W-1:0]           dq_in,
  output logic [DQ_W-1:0]           dq_out,
  output logic                      dq_oe,
  output logic                      dqs_t,
  output logic                      rd_valid,
  output logic [BL*DQ_W-1:0]        rd_data,
  output logic [TAG_W-1:0]          rd_tag,
  output logic                      burst_done,
  output logic [$clog2(DEPTH):0]    q_count,
  output logic                      q_full,
  output logic                      err_overflow,
  output logic                      err_underrun,
  output logic                      err_collision
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = $clog2(BL);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef logic [BL-1:0][DQ_W-1:0] line_t;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  logic [1:0]       rw_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  line_t            wd_mem  [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  line_t            cur_wd_q, cur_wd_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  line_t            asm_q, asm_d;

  logic [DQ_W-1:0]  dq_out_q, dq_out_d;
  logic             dq_oe_q, dq_oe_d, dqs_q, dqs_d, done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  line_t            rd_data_q, rd_data_d;
  logic [TAG_W-1:0] rd_tag_q, rd_tag_d;
  logic             ovf_q, ovf_d, und_q, und_d, col_q, col_d;

  logic empty, full, last_beat, pop, push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    last_beat = (state_q != IDLE) && (beat_q == BW'(BL - 1));
    pop       = rw_rdy && !empty && ((state_q == IDLE) || last_beat);
    // A pop in the same cycle frees the slot, so a push into a full queue is kept.
    push_ok   = cmd_push && (!full || pop);

    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (cmd_push && full && !pop);
    und_d = und_q | (rw_rdy && empty);
    col_d = col_q | (rw_rdy && (state_q != IDLE) && !last_beat);
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cur_wd_d  = cur_wd_q;
    cur_tag_d = cur_tag_q;
    if (pop) begin
      state_d   = (rw_mem[rd_ptr_q] == 2'b10) ? WRITE : READ;
      beat_d    = '0;
      cur_wd_d  = wd_mem[rd_ptr_q];
      cur_tag_d = tag_mem[rd_ptr_q];
    end else if (state_q != IDLE) begin
      if (last_beat) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    // Pin outputs are registered from the next-beat state.
    dq_oe_d  = (state_d == WRITE);
    dq_out_d = (state_d == WRITE) ? cur_wd_d[beat_d] : '0;
    dqs_d    = (state_d != IDLE) && !beat_d[0];
    done_d   = (state_d != IDLE) && (beat_d == BW'(BL - 1));

    asm_d = asm_q;
    if (state_q == READ) asm_d[beat_q] = dq_in;
    rd_valid_d = (state_q == READ) && last_beat;
    rd_data_d  = rd_valid_d ? asm_d     : rd_data_q;
    rd_tag_d   = rd_valid_d ? cur_tag_q : rd_tag_q;
  end

  always_ff @(posedge clock_t) begin
    if (!reset && push_ok) begin
      rw_mem[wr_ptr_q]  <= cmd_rw;
      tag_mem[wr_ptr_q] <= cmd_tag;
      wd_mem[wr_ptr_q]  <= cmd_wdata;
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      beat_q     <= '0;
      cur_wd_q   <= '0;
      cur_tag_q  <= '0;
      asm_q      <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      dqs_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_tag_q   <= '0;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
      col_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      cur_wd_q   <= cur_wd_d;
      cur_tag_q  <= cur_tag_d;
      asm_q      <= asm_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      dqs_q      <= dqs_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_tag_q   <= rd_tag_d;
      ovf_q      <= ovf_d;
      und_q      <= und_d;
      col_q      <= col_d;
    end
  end

  assign dq_out        = dq_out_q;
  assign dq_oe         = dq_oe_q;
  assign dqs_t         = dqs_q;
  assign burst_done    = done_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_tag        = rd_tag_q;
  assign q_count       = count_q;
  assign q_full        = full;
  assign err_overflow  = ovf_q;
  assign err_underrun  = und_q;
  assign err_collision = col_q;

endmodule

// File: tb/tb_ddr_burst_data.sv
// Bench for ddr_burst_data: directed scenarios with literal expectations plus
// randomized traffic, all checked against a cycle-scheduled behavioural model.
module tb_ddr_burst_data;

  localparam int unsigned DQ_W  = 8;
  localparam int unsigned BL    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LW    = BL * DQ_W;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset, cmd_push, rw_rdy;
  logic [1:0]       cmd_rw;
  logic [TAG_W-1:0] cmd_tag;
  logic [LW-1:0]    cmd_wdata;
  logic [DQ_W-1:0]  dq_in, dq_out;
  logic             dq_oe, dqs_t, rd_valid, burst_done, q_full;
  logic [LW-1:0]    rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic [CW-1:0]    q_count;
  logic             err_overflow, err_underrun, err_collision;

  ddr_burst_data #(.DQ_W(DQ_W), .BL(BL), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock_t(clk), .reset(reset), .cmd_push(cmd_push), .cmd_rw(cmd_rw),
    .cmd_tag(cmd_tag), .cmd_wdata(cmd_wdata), .rw_rdy(rw_rdy), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .dqs_t(dqs_t), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_tag(rd_tag), .burst_done(burst_done),
    .q_count(q_count), .q_full(q_full), .err_overflow(err_overflow),
    .err_underrun(err_underrun), .err_collision(err_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endfunction

  // Behavioural model: each accepted burst schedules its pin values by cycle number.
  typedef struct { logic [1:0] rw; logic [TAG_W-1:0] tag; logic [LW-1:0] wd; } cmd_t;
  typedef struct { int cyc; int first; logic [TAG_W-1:0] tag; } rd_t;

  cmd_t             mq[$];
  rd_t              rq[$];
  logic [DQ_W-1:0]  e_out[int];
  logic             e_oe[int], e_dqs[int], e_done[int];
  logic [DQ_W-1:0]  dq_log[int];
  int               busy_until = -1000;
  logic             m_ovf, m_und, m_col, model_ok = 1'b0, exp_rdv;
  logic [LW-1:0]    m_rd_data;
  logic [TAG_W-1:0] m_rd_tag;

  always @(negedge clk) begin
    if (model_ok) begin
      exp_rdv = 1'b0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        exp_rdv = 1'b1;
        for (int i = 0; i < BL; i++) m_rd_data[i*DQ_W +: DQ_W] = dq_log[rq[0].first + i];
        m_rd_tag = rq[0].tag;
        rq.delete(0);
      end
      chk("dq_oe",      dq_oe,      e_oe.exists(cyc)   ? e_oe[cyc]   : 1'b0);
      chk("dq_out",     dq_out,     e_out.exists(cyc)  ? e_out[cyc]  : '0);
      chk("dqs_t",      dqs_t,      e_dqs.exists(cyc)  ? e_dqs[cyc]  : 1'b0);
      chk("burst_done", burst_done, e_done.exists(cyc) ? e_done[cyc] : 1'b0);
      chk("rd_valid",   rd_valid,   exp_rdv);
      chk("rd_data",    rd_data,    m_rd_data);
      chk("rd_tag",     rd_tag,     m_rd_tag);
      chk("q_count",    q_count,    mq.size());
      chk("q_full",     q_full,     mq.size() == DEPTH);
      chk("err_ovf",    err_overflow,  m_ovf);
      chk("err_und",    err_underrun,  m_und);
      chk("err_col",    err_collision, m_col);
    end

    dq_log[cyc] = dq_in;
    if (reset) begin
      mq.delete(); rq.delete();
      e_out.delete(); e_oe.delete(); e_dqs.delete(); e_done.delete();
      busy_until = -1000;
      m_ovf = 1'b0; m_und = 1'b0; m_col = 1'b0;
      m_rd_data = '0; m_rd_tag = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      cmd_t c;
      logic popped;
      popped = 1'b0;
      if (rw_rdy && mq.size() == 0) m_und = 1'b1;
      if (rw_rdy && cyc < busy_until) m_col = 1'b1;
      if (rw_rdy && mq.size() > 0 && cyc >= busy_until) begin
        popped = 1'b1;
        c = mq.pop_front();
        busy_until = cyc + BL;
        for (int i = 0; i < BL; i++) begin
          e_oe[cyc+1+i]  = (c.rw == 2'b10);
          e_out[cyc+1+i] = (c.rw == 2'b10) ? c.wd[i*DQ_W +: DQ_W] : '0;
          e_dqs[cyc+1+i] = (i % 2 == 0);
        end
        e_done[cyc+BL] = 1'b1;
        if (c.rw != 2'b10) rq.push_back('{cyc: cyc + BL + 1, first: cyc + 1, tag: c.tag});
      end
      if (cmd_push) begin
        if (mq.size() < DEPTH) mq.push_back('{rw: cmd_rw, tag: cmd_tag, wd: cmd_wdata});
        else m_ovf = 1'b1;
      end
      if (popped && mq.size() > DEPTH) $display("FAIL model queue overrun at cycle %0d", cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dq_in = DQ_W'($urandom);
  endtask

  task automatic idle_in();
    cmd_push = 1'b0; rw_rdy = 1'b0; cmd_rw = 2'b00; cmd_tag = '0; cmd_wdata = '0;
  endtask

  initial begin
    logic [LW-1:0] wd;
    reset = 1'b1;
    dq_in = '0;
    idle_in();
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_dq_oe", dq_oe, 1'b0);
    chk("reset_q_count", q_count, 0);

    // Write burst tag 3, beats 0x10..0x17.
    for (int i = 0; i < BL; i++) wd[i*DQ_W +: DQ_W] = DQ_W'(8'h10 + i);
    cmd_push = 1'b1; cmd_rw = 2'b10; cmd_tag = 4'd3; cmd_wdata = wd;
    tick();
    idle_in(); rw_rdy = 1'b1;
    chk("t1_q_count_pre", q_count, 1);
    tick();
    rw_rdy = 1'b0;
    for (int i = 0; i < BL; i++) begin
      chk("t1_dq_oe", dq_oe, 1'b1);
      chk("t1_dq_out", dq_out, 8'h10 + i);
      chk("t1_dqs", dqs_t, (i % 2 == 0));
      chk("t1_done", burst_done, (i == BL - 1));
      chk("t1_q_count", q_count, 0);
      tick();
    end
    chk("t1_idle_oe", dq_oe, 1'b0);
    chk("t1_idle_dqs", dqs_t, 1'b0);

    // Read burst tag 9 with dq_in = 0xA0+i.
    cmd_push = 1'b1; cmd_rw = 2'b01; cmd_tag = 4'd9;
    tick();
    idle_in(); rw_rdy = 1'b1;
    tick();
    rw_rdy = 1'b0;
    for (int i = 0; i < BL; i++) begin
      dq_in = DQ_W'(8'hA0 + i);
      chk("t2_dq_oe", dq_oe, 1'b0);
      chk("t2_rd_valid_early", rd_valid, 1'b0);
      tick();
    end
    chk("t2_rd_valid", rd_valid, 1'b1);
    chk("t2_rd_tag", rd_tag, 4'd9);
    chk("t2_rd_data", rd_data, 64'hA7A6A5A4A3A2A1A0);
    tick();
    chk("t2_rd_valid_off", rd_valid, 1'b0);
    chk("t2_rd_data_hold", rd_data, 64'hA7A6A5A4A3A2A1A0);

    // Back-to-back write tag 1 then read tag 2.
    cmd_push = 1'b1; cmd_rw = 2'b10; cmd_tag = 4'd1; cmd_wdata = {$urandom, $urandom};
    tick();
    cmd_rw = 2'b01; cmd_tag = 4'd2;
    tick();
    idle_in(); rw_rdy = 1'b1;
    tick();
    rw_rdy = 1'b0;
    repeat (BL - 1) tick();
    chk("t3_last_done", burst_done, 1'b1);
    chk("t3_last_oe", dq_oe, 1'b1);
    rw_rdy = 1'b1;
    tick();
    rw_rdy = 1'b0;
    chk("t3_gapless_oe", dq_oe, 1'b0);
    chk("t3_gapless_dqs", dqs_t, 1'b1);
    repeat (BL) tick();
    chk("t3_rd_valid", rd_valid, 1'b1);
    chk("t3_rd_tag", rd_tag, 4'd2);
    chk("t3_errs", {err_overflow, err_underrun, err_collision}, 3'b000);

    // Overflow: five pushes into a four-deep queue, then push+pop while full.
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        chk("t4_full_after4", q_full, 1'b1);
        chk("t4_no_ovf_yet", err_overflow, 1'b0);
      end
      cmd_push = 1'b1; cmd_rw = (k % 2 == 0) ? 2'b10 : 2'b01; cmd_tag = TAG_W'(k);
      cmd_wdata = {$urandom, $urandom};
      tick();
    end
    idle_in();
    chk("t4_q_count", q_count, 4);
    chk("t4_q_full", q_full, 1'b1);
    chk("t4_ovf", err_overflow, 1'b1);
    cmd_push = 1'b1; cmd_rw = 2'b10; cmd_tag = 4'd7; rw_rdy = 1'b1;
    tick();
    idle_in();
    chk("t4_pushpop_count", q_count, 4);
    chk("t4_pushpop_full", q_full, 1'b1);
    for (int b = 0; b < 4; b++) begin
      repeat (BL - 1) tick();
      rw_rdy = 1'b1;
      tick();
      rw_rdy = 1'b0;
    end
    repeat (BL + 2) tick();
    chk("t4_drained", q_count, 0);

    // Underrun and collision.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ovf_cleared", err_overflow, 1'b0);
    rw_rdy = 1'b1;
    tick();
    rw_rdy = 1'b0;
    chk("t5_underrun", err_underrun, 1'b1);
    chk("t5_idle_oe", dq_oe, 1'b0);
    chk("t5_no_col", err_collision, 1'b0);
    cmd_push = 1'b1; cmd_rw = 2'b10; cmd_tag = 4'd5; cmd_wdata = {$urandom, $urandom};
    tick();
    cmd_tag = 4'd6; cmd_wdata = {$urandom, $urandom}; rw_rdy = 1'b1;
    tick();
    idle_in();
    repeat (3) tick();
    rw_rdy = 1'b1;
    tick();
    rw_rdy = 1'b0;
    chk("t5_collision", err_collision, 1'b1);
    chk("t5_queue_kept", q_count, 1);
    chk("t5_burst_runs", dq_oe, 1'b1);
    repeat (4) tick();

    // Reset at beat 4 of a write.
    rw_rdy = 1'b1;
    tick();
    rw_rdy = 1'b0;
    repeat (4) tick();
    chk("t6_beat4_oe", dq_oe, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_oe", dq_oe, 1'b0);
    chk("t6_q_count", q_count, 0);
    chk("t6_done", burst_done, 1'b0);
    chk("t6_errs", {err_overflow, err_underrun, err_collision}, 3'b000);
    repeat (5) tick();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      cmd_push  = ($urandom_range(0, 2) == 0);
      cmd_rw    = 2'($urandom);
      cmd_tag   = TAG_W'($urandom);
      cmd_wdata = {$urandom, $urandom};
      rw_rdy    = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle_in();
    reset = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_burst_data.md
Name: ddr_burst_data

Overview:
- Data-phase engine directly downstream of the CAS-to-data timing stage.
- Holds a queue of issued read/write commands, pushed at CAS issue.
- On each rw_rdy pulse from the timing stage, pops the oldest command and runs one burst on the DQ bus:
  - write: serializes the stored write payload onto dq_out/dqs;
  - read: captures dq_in beats and returns the assembled line to the controller.

Parameters:
DQ_W, 8, DQ bus width (bits per beat)
BL, 8, beats per burst; power of 2, >=2
DEPTH, 4, command queue entries; power of 2
TAG_W, 4, transaction tag width

Ports:
clock_t  in  1  main clock; all logic on rising edge
reset  in  1  synchronous active-high reset
cmd_push  in  1  enqueue command this cycle (driven alongside CAS issue)
cmd_rw  in  2  2'b01 read, 2'b10 write; other codes are queued and treated as read
cmd_tag  in  TAG_W  transaction tag
cmd_wdata  in  BL*DQ_W  write payload; beat i = bits [i*DQ_W +: DQ_W]
rw_rdy  in  1  one-cycle pulse: data phase starts next cycle
dq_in  in  DQ_W  read data from memory model
dq_out  out  DQ_W  write data beat
dq_oe  out  1  DQ output enable
dqs_t  out  1  strobe; high on even beats, low on odd beats, low when idle
rd_valid  out  1  one-cycle pulse: rd_data/rd_tag valid
rd_data  out  BL*DQ_W  assembled read line, beat i at [i*DQ_W +: DQ_W]
rd_tag  out  TAG_W  tag of completed read
burst_done  out  1  pulse in last-beat cycle of any burst
q_count  out  $clog2(DEPTH)+1  occupied entries
q_full  out  1  q_count==DEPTH
err_overflow  out  1  sticky: push while full (command dropped)
err_underrun  out  1  sticky: rw_rdy with empty queue
err_collision  out  1  sticky: rw_rdy while burst has >1 beat remaining

Behaviour:
- Reset values:
  - all outputs 0; queue flushed; FSM to IDLE; beat counter 0; sticky errors cleared.
  - Reset mid-burst aborts it: dq_oe=0 on the cycle after the reset edge, and no rd_valid for the aborted read.
- Queue: circular FIFO with DEPTH entries {rw, tag, wdata}.
  - Push and pop in the same cycle are both honoured and q_count is unchanged.
  - A push when full that coincides with a pop is accepted; no overflow flagged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, WRITE, READ; beat counter 0..BL-1.
  - IDLE: on accepted rw_rdy (cycle N), pop head. Go to WRITE if head rw==2'b10, else READ.
  - WRITE/READ: beat i occupies cycle N+1+i. The counter increments each cycle.
  - At beat BL-1, burst_done=1. Next state is IDLE, or a new burst if rw_rdy is accepted in that same cycle.
- Accepted rw_rdy means: queue non-empty, and FSM is IDLE or at beat BL-1. Back-to-back bursts are gapless.
- rw_rdy with an empty queue: err_underrun set, ignored.
- rw_rdy in a burst at beat < BL-1: err_collision set, ignored, no pop.
- If both error conditions hold, both flags are set.
- WRITE:
  - dq_oe=1 and dq_out=wdata beat i in cycle N+1+i.
  - dqs_t = ~i[0] (registered outputs).
- READ:
  - dq_oe=0; dqs_t toggles as in WRITE.
  - dq_in is sampled at the end of each beat cycle into slot i of a shift/assembly register.
  - rd_valid=1 for one cycle in N+BL+1, with rd_data and rd_tag.
  - rd_data/rd_tag hold their value until the next read completes.
- Idle: dq_out=0, dq_oe=0, dqs_t=0.

Test Plan:
- Reset, then push write tag 3 with wdata beats 0x10..0x17; rw_rdy in cycle 5 -> cycles 6..13: dq_oe=1, dq_out 0x10..0x17, dqs_t 1,0,1,0...; burst_done in cycle 13; q_count 1->0.
- Push read tag 9; rw_rdy in cycle N; dq_in=0xA0+i in beat i -> rd_valid only in N+9, rd_tag=9, rd_data beat i=0xA0+i, dq_oe=0 throughout.
- Push W(tag1), R(tag2); rw_rdy in cycle N, rw_rdy again in N+8 -> write beats N+1..N+8, read beats N+9..N+16 with no gap; rd_valid in N+17 with tag2; err flags 0.
- Push 5 commands with DEPTH=4 -> q_full=1 after 4 pushes, err_overflow=1, q_count=4. Push+pop in same cycle while full -> q_count stays 4, no new error.
- rw_rdy with empty queue -> err_underrun=1, outputs idle. rw_rdy at beat 3 of a burst -> err_collision=1, burst completes unchanged, queue untouched.
- Assert reset at beat 4 of a write -> next cycle dq_oe=0, q_count=0, state IDLE, no burst_done, sticky errors cleared.
